red_xor_accu: RTL and testbench

RED_XOR_ACCU -- requirements
Module: red_xor_accu

---
 rtl/lau_pkg.sv | 21 ++
 rtl/red_xor_accu_redxor.sv | 13 +
 rtl/red_xor_accu.sv | 116 +++++++++++
 tb/tb_red_xor_accu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lau_pkg.sv
// Shared definitions for the parity accumulator.
//   state_t   : controller states (ACC accepting beats, HOLD presenting result)
//   log2floor : floor(log2(n)) for elaboration-time width derivation
package lau_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Highest set bit position of n; returns 0 for n <= 1.
   function automatic int log2floor(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((n >> i) != 0) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/red_xor_accu_redxor.sv
// Word parity reducer: p = XOR of all bits of d.
//   d : input  [width-1:0] data word
//   p : output 1-bit reduction XOR
module RedXor #(
   parameter int width = 8
) (
   input  logic [width-1:0] d,
   output logic             p
);

   assign p = ^d;

endmodule

// File: rtl/red_xor_accu.sv
// Frame parity accumulator with valid/ready handshakes on both sides.
// Beats are XOR-reduced and accumulated until the last beat of a frame;
// the frame parity, parity error, saturating beat count and overflow flag
// are then held on the z_* port until consumed.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   a_valid_i/a_ready_o : input beat handshake
//   a_data_i            : beat data word
//   a_last_i, a_par_i   : end-of-frame marker and expected parity (last beat)
//   z_valid_o/z_ready_i : result handshake
//   z_par_o, z_err_o    : computed parity, mismatch against expected
//   z_cnt_o, z_ovf_o    : saturating beat count, count overflow
//
// state | meaning
// ------+------------------------------------------------------------
// ACC   | accepting beats, accumulating parity and count
// HOLD  | result presented on z_*, input stalled until z handshake
module red_xor_accu
   import lau_pkg::*;
#(
   parameter int width    = 8,
   parameter int maxbeats = 256,
   parameter bit odd      = 1'b0,
   localparam int cntw    = log2floor(maxbeats) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             a_valid_i,
   output logic             a_ready_o,
   input  logic [width-1:0] a_data_i,
   input  logic             a_last_i,
   input  logic             a_par_i,
   output logic             z_valid_o,
   input  logic             z_ready_i,
   output logic             z_par_o,
   output logic             z_err_o,
   output logic [cntw-1:0]  z_cnt_o,
   output logic             z_ovf_o
);

   localparam logic [cntw-1:0] cnt_max = {cntw{1'b1}};

   state_t            state;
   state_t            state_nx;
   logic              acc;
   logic [cntw-1:0]   cnt;
   logic              ovf;
   logic              beat_par;
   logic              acc_nx;
   logic [cntw-1:0]   cnt_nx;
   logic              ovf_nx;
   logic              par_nx;
   logic              a_hs;
   logic              z_hs;

   RedXor #(.width(width)) u_redxor (
      .d (a_data_i),
      .p (beat_par)
   );

   assign a_hs = a_valid_i & a_ready_o;
   assign z_hs = z_valid_o & z_ready_i;

   // Count sticks at all-ones; an increment attempted there marks overflow.
   assign acc_nx = acc ^ beat_par;
   assign cnt_nx = (cnt == cnt_max) ? cnt : cnt + 1'b1;
   assign ovf_nx = ovf | (cnt == cnt_max);
   assign par_nx = acc_nx ^ odd;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ACC;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ACC:     if (a_valid_i && a_last_i) state_nx = HOLD;
         HOLD:    if (z_ready_i)             state_nx = ACC;
         default: state_nx = ACC;
      endcase
   end

   // Ready is purely state-based: the release cycle of HOLD never accepts,
   // which yields one bubble between frames.
   always_comb begin
      a_ready_o = (state == ACC);
      z_valid_o = (state == HOLD);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc     <= 1'b0;
         cnt     <= '0;
         ovf     <= 1'b0;
         z_par_o <= 1'b0;
         z_err_o <= 1'b0;
         z_cnt_o <= '0;
         z_ovf_o <= 1'b0;
      end else if (a_hs) begin
         acc <= acc_nx;
         cnt <= cnt_nx;
         ovf <= ovf_nx;
         if (a_last_i) begin
            z_par_o <= par_nx;
            z_err_o <= par_nx ^ a_par_i;
            z_cnt_o <= cnt_nx;
            z_ovf_o <= ovf_nx;
         end
      end else if (z_hs) begin
         acc <= 1'b0;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_red_xor_accu.sv
// Three DUT variants share one stimulus stream: default, maxbeats=4, odd=1.
module tb_red_xor_accu;

   logic       clk_sys = 1'b0;
   logic       rst = 1'b1;
   logic       a_valid = 1'b0;
   logic [7:0] a_data = '0;
   logic       a_last = 1'b0;
   logic       a_par = 1'b0;
   logic       z_ready = 1'b0;

   logic       a_ready [3];
   logic       z_valid [3];
   logic       z_par   [3];
   logic       z_err   [3];
   logic       z_ovf   [3];
   logic [8:0] z_cnt0;
   logic [2:0] z_cnt1;
   logic [8:0] z_cnt2;

   always #5 clk_sys = ~clk_sys;

   red_xor_accu u_dut0 (
      .clk_i(clk_sys), .rst_i(rst), .a_valid_i(a_valid), .a_ready_o(a_ready[0]),
      .a_data_i(a_data), .a_last_i(a_last), .a_par_i(a_par), .z_valid_o(z_valid[0]),
      .z_ready_i(z_ready), .z_par_o(z_par[0]), .z_err_o(z_err[0]), .z_cnt_o(z_cnt0),
      .z_ovf_o(z_ovf[0])
   );

   red_xor_accu #(.maxbeats(4)) u_dut1 (
      .clk_i(clk_sys), .rst_i(rst), .a_valid_i(a_valid), .a_ready_o(a_ready[1]),
      .a_data_i(a_data), .a_last_i(a_last), .a_par_i(a_par), .z_valid_o(z_valid[1]),
      .z_ready_i(z_ready), .z_par_o(z_par[1]), .z_err_o(z_err[1]), .z_cnt_o(z_cnt1),
      .z_ovf_o(z_ovf[1])
   );

   red_xor_accu #(.odd(1'b1)) u_dut2 (
      .clk_i(clk_sys), .rst_i(rst), .a_valid_i(a_valid), .a_ready_o(a_ready[2]),
      .a_data_i(a_data), .a_last_i(a_last), .a_par_i(a_par), .z_valid_o(z_valid[2]),
      .z_ready_i(z_ready), .z_par_o(z_par[2]), .z_err_o(z_err[2]), .z_cnt_o(z_cnt2),
      .z_ovf_o(z_ovf[2])
   );

   typedef struct {
      bit [2:0] par;
      bit [2:0] err;
      bit [2:0] ovf;
      int       c0;
      int       c1;
      int       c2;
   } exp_t;

   exp_t     sb[$];
   int       checks = 0;
   int       errors = 0;

   bit       m_hold;
   bit [2:0] m_acc;
   bit [2:0] m_ovf;
   int       m_cnt [3];
   int       sat   [3] = '{511, 7, 511};
   bit [2:0] oddv = 3'b100;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int zcnt(input int i);
      if (i == 0) return int'(z_cnt0);
      if (i == 1) return int'(z_cnt1);
      return int'(z_cnt2);
   endfunction

   function automatic int ecnt(input exp_t e, input int i);
      if (i == 0) return e.c0;
      if (i == 1) return e.c1;
      return e.c2;
   endfunction

   task automatic model_clear();
      m_acc = '0;
      m_ovf = '0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
   endtask

   task automatic model_update();
      exp_t e;
      if (rst) begin
         m_hold = 1'b0;
         model_clear();
         sb.delete();
      end else if (!m_hold && a_valid) begin
         for (int i = 0; i < 3; i++) begin
            m_acc[i] = m_acc[i] ^ (^a_data);
            if (m_cnt[i] == sat[i]) m_ovf[i] = 1'b1;
            else                    m_cnt[i] = m_cnt[i] + 1;
         end
         if (a_last) begin
            for (int i = 0; i < 3; i++) begin
               e.par[i] = m_acc[i] ^ oddv[i];
               e.err[i] = e.par[i] ^ a_par;
               e.ovf[i] = m_ovf[i];
            end
            e.c0 = m_cnt[0];
            e.c1 = m_cnt[1];
            e.c2 = m_cnt[2];
            sb.push_back(e);
            m_hold = 1'b1;
         end
      end else if (m_hold && z_ready) begin
         m_hold = 1'b0;
         model_clear();
         if (sb.size() != 0) void'(sb.pop_front());
      end
   endtask

   // Every cycle: handshake flags against the model state, and while a
   // result is held its z_* fields against the scoreboard head (which also
   // proves they stay stable under backpressure).
   task automatic check_outputs();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("a_ready%0d", i), a_ready[i], !m_hold);
         chk($sformatf("z_valid%0d", i), z_valid[i], m_hold);
         if (m_hold && sb.size() != 0) begin
            chk($sformatf("z_par%0d", i), z_par[i], sb[0].par[i]);
            chk($sformatf("z_err%0d", i), z_err[i], sb[0].err[i]);
            chk($sformatf("z_cnt%0d", i), zcnt(i), ecnt(sb[0], i));
            chk($sformatf("z_ovf%0d", i), z_ovf[i], sb[0].ovf[i]);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk_sys);
      check_outputs();
      @(posedge clk_sys);
      model_update();
      #1;
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_par"}, z_par[i], 0);
         chk({tag, "_err"}, z_err[i], 0);
         chk({tag, "_cnt"}, zcnt(i), 0);
         chk({tag, "_ovf"}, z_ovf[i], 0);
      end
   endtask

   task automatic beat(input logic [7:0] d, input logic l, input logic p);
      bit done;
      bit taken;
      done = 1'b0;
      a_valid = 1'b1;
      a_data  = d;
      a_last  = l;
      a_par   = p;
      z_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (!done) begin
            taken = !m_hold;
            tick();
            done = taken;
         end
      end
      if (!done) chk("beat_timeout", 0, 1);
      a_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      a_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic drain();
      z_ready = 1'b1;
      a_valid = 1'b0;
      for (int k = 0; k < 8; k++) if (m_hold) tick();
      if (m_hold) chk("drain_timeout", 0, 1);
      tick();
   endtask

   initial begin
      m_hold = 1'b0;
      model_clear();
      @(posedge clk_sys);
      #1;
      tick();
      rst = 1'b0;
      check_zero("reset");

      // single beat 0xA5, even parity
      beat(8'hA5, 1'b1, 1'b0);
      drain();

      // three-beat frame with gaps, then again with mismatched parity
      for (int r = 0; r < 2; r++) begin
         beat(8'h01, 1'b0, 1'b1);
         idle(2);
         beat(8'h03, 1'b0, 1'b0);
         beat(8'h80, 1'b1, logic'(r));
         drain();
      end

      // backpressure with a pending beat that must not be lost
      beat(8'h5A, 1'b1, 1'b1);
      z_ready = 1'b0;
      a_valid = 1'b1;
      a_data  = 8'h3C;
      a_last  = 1'b1;
      a_par   = 1'b0;
      repeat (5) tick();
      z_ready = 1'b1;
      tick();
      tick();
      a_valid = 1'b0;
      drain();

      // 9 beats: saturates the maxbeats=4 variant, then a clean 2-beat frame
      for (int i = 0; i < 9; i++) beat(8'(i * 37 + 1), (i == 8), 1'b0);
      drain();
      beat(8'h07, 1'b0, 1'b0);
      beat(8'h10, 1'b1, 1'b0);
      drain();

      // all-zero word with odd parity expectation
      beat(8'h00, 1'b1, 1'b1);
      drain();

      // reset mid-frame discards the partial frame
      beat(8'hFF, 1'b0, 1'b0);
      beat(8'h01, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("midrst");
      beat(8'h01, 1'b1, 1'b0);
      drain();

      // reset while a result is held
      beat(8'h13, 1'b1, 1'b0);
      z_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("holdrst");

      // random frames with gaps and random consumer stalls
      for (int f = 0; f < 25; f++) begin
         int len;
         len = $urandom_range(1, 12);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            beat(8'($urandom), (b == len - 1), 1'($urandom));
         end
         z_ready = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
